// File: rtl/vga_pkg.sv
// Shared timing constants, types and decode helpers for the VGA raster timing block.
package vga_pkg;

  localparam int CNT_W     = 11;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  // Bit order matters: the delay line carries this struct as a flat 3-bit word.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
  } sync_t;

  function automatic int timing_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic phase_e phase_of(input logic [CNT_W-1:0] c, input int act, input int fp,
                                      input int syn);
    int v;
    v = int'(c);
    if (v < act) return PH_ACTIVE;
    if (v < act + fp) return PH_FRONT;
    if (v < act + fp + syn) return PH_SYNC;
    return PH_BACK;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// DEPTH-stage, 3-bit shift register with synchronous reset to RST_VAL; DEPTH=0 is a wire.
module sync_delay #(
  parameter int         DEPTH   = 0,
  parameter logic [2:0] RST_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][2:0] pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: x/y counters, de and sync strobes with an optional output delay line.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame counter port.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int PIPE_DLY  = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]       frame
`endif
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT || PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_params
    $error("vga_timing: illegal parameters (totals must fit 11 bits, PIPE_DLY 0..4)");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic h_wrap, v_wrap;
  assign h_wrap = (x == H_LAST);
  assign v_wrap = (y == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (h_wrap) begin
      x <= '0;
      y <= v_wrap ? '0 : y + 1'b1;
    end else begin
      x <= x + 1'b1;
    end
  end

  assign line_start  = (x == '0);
  assign frame_start = (x == '0) && (y == '0);

  // Pure counter decode: the phase is a function of the counters alone.
  phase_e h_ph, v_ph;
  sync_t  raw, dly;

  assign h_ph = phase_of(x, H_ACTIVE, H_FP, H_SYNC);
  assign v_ph = phase_of(y, V_ACTIVE, V_FP, V_SYNC);

  always_comb begin
    raw       = '0;
    raw.de    = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
    raw.hsync = (h_ph == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    raw.vsync = (v_ph == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
  end

  localparam sync_t IDLE = '{de: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};

  sync_delay #(
    .DEPTH  (PIPE_DLY),
    .RST_VAL(IDLE)
  ) u_sync_delay (
    .clk(clk),
    .rst(rst),
    .d  (raw),
    .q  (dly)
  );

  assign de    = dly.de;
  assign hsync = dly.hsync;
  assign vsync = dly.vsync;

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) frame <= '0;
    else if (h_wrap && v_wrap) frame <= frame + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing on a shrunken raster with a 3-deep sync delay line.
module tb_vga_timing;

  localparam int HA = 10, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PD = 3;
  localparam bit HP = 1'b0, VP = 1'b0;
  localparam bit [2:0] INACT = {1'b0, !HP, !VP};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x, y;
  logic        de, hsync, vsync, line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0]  frame;
`endif

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .PIPE_DLY(PD)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame(frame)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: the raster position is just the cycle count since the last reset edge.
  int       c = 0;
  bit [2:0] q[$];
  bit [2:0] prev_raw = INACT;

  function automatic bit [2:0] ref_raw(input int cc);
    int  xx, yy;
    bit  d, h, v;
    xx = cc % HT;
    yy = (cc / HT) % VT;
    d  = (xx < HA) && (yy < VA);
    h  = (xx >= HA + HF && xx < HA + HF + HS) ? HP : !HP;
    v  = (yy >= VA + VF && yy < VA + VF + VS) ? VP : !VP;
    return {d, h, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic step(input bit r);
    bit [2:0] e, dump;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      c = 0;
      q.delete();
      for (int i = 0; i < PD; i++) q.push_back(INACT);
    end else begin
      c++;
      q.push_back(prev_raw);
      dump = q.pop_front();
    end
    e        = q[0];
    prev_raw = ref_raw(c);
    chk("x", 32'(x), 32'(c % HT));
    chk("y", 32'(y), 32'((c / HT) % VT));
    chk("de", 32'(de), 32'(e[2]));
    chk("hsync", 32'(hsync), 32'(e[1]));
    chk("vsync", 32'(vsync), 32'(e[0]));
    chk("line_start", 32'(line_start), 32'(c % HT == 0));
    chk("frame_start", 32'(frame_start), 32'(c % FT == 0));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("frame", 32'(frame), 32'((c / FT) % 256));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, decnt;

    // reset held, then release and run two full frames
    repeat (10) step(1'b1);
    step(1'b0);
    chk("rel_x0", 32'(x), 32'd1);
    repeat (2 * FT + 5) step(1'b0);

    // one-cycle reset while hsync is active mid-frame: the pipeline must flush
    while (!((c % HT) == HA + HF + 1 && ((c / HT) % VT) == 3)) step(1'b0);
    step(1'b1);
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_hs", 32'(hsync), 32'(!HP));
    repeat (PD) begin
      step(1'b0);
      chk("flush_hs", 32'(hsync), 32'(!HP));
    end

    // random short resets sprinkled over a few frames
    repeat (3000) step(($urandom % 40) == 0);

    // long clean run: frame period, de count per frame and frame counter wrap
    step(1'b1);
    gap   = 0;
    decnt = 0;
    repeat (258 * FT) begin
      step(1'b0);
      gap++;
      if (frame_start) begin
        chk("fs_gap", 32'(gap), 32'(FT));
        chk("de_per_frame", 32'(decnt), 32'(HA * VA));
        gap   = 0;
        decnt = 0;
      end
      if (de) decnt++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
